// File: rtl/fc_seq_mac.sv
// Time-multiplexed fully-connected neuron: LANES products per beat, bias added after the last beat.
// Optional build macro FC_SEQ_MAC_RELU_EN clamps negative results to zero.
module fc_seq_mac #(
  parameter int BIT_WIDTH = 32,
  parameter int OUT_WIDTH = 64,
  parameter int N_IN      = 120,
  parameter int LANES     = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [BIT_WIDTH*LANES-1:0]                        in_data,
  input  logic [BIT_WIDTH*LANES-1:0]                        in_weights,
  input  logic [BIT_WIDTH-1:0]                              bias,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [OUT_WIDTH-1:0]                              out,
  output logic [$clog2(((N_IN+LANES-1)/LANES)+1)-1:0]       beat_cnt
);

  localparam int NBEATS = (N_IN + LANES - 1) / LANES;
  localparam int CNT_W  = $clog2(NBEATS + 1);

  typedef enum logic [1:0] {S_ACCUM, S_BIAS, S_HOLD} state_t;

  state_t                        state_q, state_d;
  logic signed [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0]   out_q, out_d;
  logic signed [BIT_WIDTH-1:0]   bias_q, bias_d;
  logic        [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic signed [OUT_WIDTH-1:0]   lane_sum;
  int                            lane_base;

  function automatic logic signed [OUT_WIDTH-1:0] mul_ext(
    input logic signed [BIT_WIDTH-1:0] a,
    input logic signed [BIT_WIDTH-1:0] b
  );
    logic signed [2*BIT_WIDTH-1:0] p;
    p = (2*BIT_WIDTH)'(a) * (2*BIT_WIDTH)'(b);
    return OUT_WIDTH'(p);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] ext_bias(input logic signed [BIT_WIDTH-1:0] b);
    return OUT_WIDTH'(b);
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] finalize(input logic signed [OUT_WIDTH-1:0] x);
`ifdef FC_SEQ_MAC_RELU_EN
    return x[OUT_WIDTH-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // Lanes past the end of the vector are skipped by a known select so X data cannot leak in
  always_comb begin
    lane_base = int'(beat_cnt_q) * LANES;
    lane_sum  = '0;
    for (int k = 0; k < LANES; k++) begin
      if (lane_base + k < N_IN)
        lane_sum = lane_sum + mul_ext(in_data[BIT_WIDTH*k +: BIT_WIDTH],
                                      in_weights[BIT_WIDTH*k +: BIT_WIDTH]);
    end
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    out_d      = out_q;
    bias_d     = bias_q;
    beat_cnt_d = beat_cnt_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d      = ((beat_cnt_q == '0) ? '0 : acc_q) + lane_sum;
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == '0)
            bias_d = bias;
          if (beat_cnt_q == CNT_W'(NBEATS - 1))
            state_d = S_BIAS;
        end
      end
      S_BIAS: begin
        out_d      = finalize(acc_q + ext_bias(bias_q));
        beat_cnt_d = '0;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = S_ACCUM;
      end
      default: state_d = S_ACCUM;
    endcase
  end

  // State register; bias_q needs no reset since it is always written before use
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_ACCUM;
      acc_q      <= '0;
      out_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      out_q      <= out_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    bias_q <= bias_d;
  end

  assign out      = out_q;
  assign beat_cnt = beat_cnt_q;

endmodule
